// File: rtl/mem_port_arbiter_if.sv
// Bundle of the fetch, data and memory-side signals around mem_port_arbiter.
// master = core requesters plus memory; slave = the arbiter.
interface mem_port_arbiter_if #(
   parameter int ADDR_W = 10,
   parameter int DATA_W = 32
);
   logic              if_req;
   logic [ADDR_W-1:0] if_addr;
   logic              if_gnt;
   logic              if_rvalid;
   logic [DATA_W-1:0] if_rdata;

   logic              d_req;
   logic              d_we;
   logic [ADDR_W-1:0] d_addr;
   logic [DATA_W-1:0] d_wdata;
   logic              d_gnt;
   logic              d_rvalid;
   logic [DATA_W-1:0] d_rdata;

   logic              mem_en;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;

   modport master (
      output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
      input  if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
             mem_en, mem_we, mem_addr, mem_wdata
   );

   modport slave (
      input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
      output if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
             mem_en, mem_we, mem_addr, mem_wdata
   );
endinterface

// File: rtl/mem_port_arbiter.sv
// Data-over-fetch arbiter for one single-port synchronous memory, pipelined 1-cycle reads.
// Define ARB_FAIRNESS_EN to build the data-streak limiter that forces a fetch grant.
module mem_port_arbiter #(
   parameter int ADDR_W       = 10,
   parameter int DATA_W       = 32,
   parameter int MAX_D_STREAK = 4
) (
   input logic                CLK,
   input logic                RSTn,
   mem_port_arbiter_if.slave  bus
);

   typedef enum logic [1:0] {
      OWN_NONE = 2'd0,
      OWN_IF   = 2'd1,
      OWN_D    = 2'd2
   } own_e;

   own_e own_q, own_d;
   logic force_if;
   logic if_gnt;
   logic d_gnt;

`ifdef ARB_FAIRNESS_EN
   localparam logic [3:0] STREAK_LIMIT = 4'(MAX_D_STREAK);

   logic [3:0] streak_q, streak_d;

   assign force_if = bus.if_req && (streak_q == STREAK_LIMIT);

   always_comb begin
      // NOTE: every always_comb output gets a default first so no path can infer a latch.
      streak_d = streak_q;
      if (if_gnt || !bus.if_req) begin
         streak_d = 4'd0;
      end else if (d_gnt) begin
         streak_d = streak_q + 4'd1;
      end
   end

   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) begin
         streak_q <= 4'd0;
      end else begin
         streak_q <= streak_d;
      end
   end
`else
   // The streak limit only matters in the fairness build.
   logic unused_streak_limit;
   assign unused_streak_limit = |4'(MAX_D_STREAK);
   assign force_if            = 1'b0;
`endif

   // Grants are gated by RSTn so nothing reaches the memory while reset is held.
   assign d_gnt  = RSTn && bus.d_req && !force_if;
   assign if_gnt = RSTn && bus.if_req && !d_gnt;

   assign bus.d_gnt     = d_gnt;
   assign bus.if_gnt    = if_gnt;
   assign bus.mem_en    = if_gnt || d_gnt;
   assign bus.mem_we    = d_gnt && bus.d_we;
   assign bus.mem_addr  = d_gnt  ? bus.d_addr :
                          if_gnt ? bus.if_addr : '0;
   assign bus.mem_wdata = d_gnt  ? bus.d_wdata : '0;

   always_comb begin
      own_d = OWN_NONE;
      if (if_gnt) begin
         own_d = OWN_IF;
      end else if (d_gnt && !bus.d_we) begin
         own_d = OWN_D;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) begin
         own_q <= OWN_NONE;
      end else begin
         own_q <= own_d;
      end
   end

   assign bus.if_rvalid = (own_q == OWN_IF);
   assign bus.d_rvalid  = (own_q == OWN_D);
   assign bus.if_rdata  = (own_q == OWN_IF) ? bus.mem_rdata : '0;
   assign bus.d_rdata   = (own_q == OWN_D)  ? bus.mem_rdata : '0;

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares one single-port synchronous memory between the core's instruction-fetch port and its data port. Each cycle it grants at most one requester, drives the memory port, and routes the one-cycle-late read data back to the requester that issued it. Fixed data-over-fetch priority keeps load/store ordering simple. An optional streak limiter stops a long run of data accesses from starving fetch.

## Interface
Parameters:
- ADDR_W, 10, word-address width of both requesters and the memory port
- DATA_W, 32, data width
- MAX_D_STREAK, 4, consecutive data grants allowed while fetch waits (fairness build only; legal range 1..15)

Ports:
- CLK  in  1  single clock; all state on rising edge
- RSTn  in  1  asynchronous, active-low reset
- if_req  in  1  fetch request; held with if_addr until if_gnt
- if_addr  in  ADDR_W  fetch address
- if_gnt  out  1  fetch accepted this cycle
- if_rvalid  out  1  fetch data valid (cycle after if_gnt)
- if_rdata  out  DATA_W  fetch data; zero when if_rvalid low
- d_req  in  1  data request; held with d_we/d_addr/d_wdata until d_gnt
- d_we  in  1  1 = write, 0 = read
- d_addr  in  ADDR_W  data address
- d_wdata  in  DATA_W  write data
- d_gnt  out  1  data request accepted this cycle
- d_rvalid  out  1  read data valid (cycle after a read d_gnt)
- d_rdata  out  DATA_W  read data; zero when d_rvalid low
- mem_en  out  1  memory access this cycle
- mem_we  out  1  memory write
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data, valid one cycle after a read mem_en

## Operation
- Arbitration is combinational within a cycle, and at most one grant is issued per cycle.
  - If d_req is high and fetch is not forced, d_gnt=1.
  - Otherwise, if if_req is high, if_gnt=1.
- mem_en = if_gnt | d_gnt.
- mem_we = d_gnt & d_we.
- mem_addr and mem_wdata come from the granted requester. When nothing is granted, mem_addr and mem_wdata are zero.
- Response owner register resp_own is one of NONE, IF or D.
  - Loaded every cycle: IF on if_gnt; D on a read d_gnt; NONE on a write d_gnt or when idle.
- if_rvalid = (resp_own==IF); d_rvalid = (resp_own==D). rdata for the owner = mem_rdata; the other requester's rdata is zero.
- Operation is fully pipelined. A grant in cycle N and a response for the grant in N-1 coexist, so back-to-back reads sustain one access per cycle.
- Writes complete at d_gnt and return no response.
- Requesters may drop req only after their grant. The arbiter does not check this.

## Timing
- Grant-to-data latency is 1 cycle for both ports. A request with no contention is granted in the cycle it is raised.
- Reset values: resp_own=NONE, streak=0, so every output is 0. While RSTn is low, both grants and mem_en are forced to 0.
- Reset mid-operation: a response pending at reset assertion is dropped. No rvalid for it ever appears after release.
- Simultaneous if_req and d_req: data wins (unless forced, see Configuration). Fetch stays requesting and is granted in the first cycle d_req is low.
- A d read granted in cycle N followed by if_gnt in N+1 gives d_rvalid in N+1 and if_rvalid in N+2.

## Configuration
- ARB_FAIRNESS_EN defined:
  - A 4-bit streak counter increments on each d_gnt while if_req is high.
  - It clears to 0 on if_gnt, and also whenever if_req is low.
  - When streak==MAX_D_STREAK and if_req is high, fetch is forced: if_gnt=1 and d_gnt=0 regardless of d_req.
- ARB_FAIRNESS_EN undefined:
  - The counter is not built and priority is strictly data first.
  - Fetch can starve indefinitely under continuous d_req.

## Test plan
- Reset, idle: RSTn low with if_req=d_req=1 -> all outputs 0. After release, with no requests -> mem_en=0 and both rvalid 0.
- Single fetch: if_req, if_addr=0x004, memory word 0x00500093 -> if_gnt in cycle N, mem_addr=0x004, if_rvalid=1 and if_rdata=0x00500093 in N+1.
- Contention: if_req=1 and d_req=1 (read 0x010) in the same cycle -> d_gnt first, if_gnt next cycle. Then d_rvalid and if_gnt fall in the same cycle, and if_rvalid follows one cycle later.
- Write: d_we=1, d_addr=0x020, d_wdata=0xDEADBEEF -> mem_we=1 for one cycle, no d_rvalid. A following read of 0x020 returns 0xDEADBEEF.
- Fairness (macro defined, MAX_D_STREAK=4): d_req and if_req held high -> grant sequence D,D,D,D,IF,D,D,D,D,IF. With the macro undefined -> if_gnt never asserts.
- Reset mid-read: RSTn pulsed low in the cycle after a read d_gnt -> no d_rvalid after release, and the next request is granted normally.
